fft_result_streamer: RTL and testbench
======================================

Name: fft_result_streamer

Overview:
Sits between the FFT core's unload port and main_fsm. Captures each 512-bin FFT frame, arriving in any index order, into a ping-pong buffer. Replays each frame in natural order, one bin per clock, onto main_fsm's FFT input interface (fft_done, fft_address, fft_read_valid, data_in_real, data_in_imag). Holds fft_done until main_fsm acknowledges the frame.

Parameters:
ADDR_W, 9, bin index width; frame length is 2**ADDR_W.
DATA_W, 18, width of each real or imaginary component (two's complement).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
xk_dv  in  1  FFT core output sample valid
xk_index  in  ADDR_W  bin index of the current FFT sample
xk_re  in  DATA_W  real part of the FFT sample
xk_im  in  DATA_W  imaginary part of the FFT sample
fsm_done  in  1  main_fsm done; acknowledges the frame currently presented
fft_done  out  1  a frame is being or has been presented; held until acknowledged
fft_address  out  ADDR_W  bin index of the sample on the data outputs
fft_read_valid  out  1  data_in_real, data_in_imag and fft_address are valid this cycle
data_in_real  out  DATA_W  bin real part
data_in_imag  out  DATA_W  bin imaginary part
overflow  out  1  one-cycle pulse: an incoming frame was dropped
drop_count  out  8  saturating count of dropped frames
busy  out  1  read side is not IDLE, or any bank is full

Behaviour:
- Reset (async): every output 0; both bank-full flags 0; wr_bank = 0; rd_bank = 0; read FSM in IDLE. RAM contents are don't-care. Reset mid-stream aborts the frame immediately; no further valid cycles follow.
- Storage: two banks of 2**ADDR_W x 2*DATA_W, single-clock, registered read with 1-cycle latency.
- Capture side:
  - On xk_dv=1 with bank wr_bank not full: write {xk_re, xk_im} to wr_bank[xk_index].
  - When that write has xk_index = all ones: set full[wr_bank] and toggle wr_bank.
  - A gap in xk_dv is legal. Order within a frame is arbitrary; only the all-ones index closes the frame.
- Drop policy: on xk_dv=1 while full[wr_bank]=1 (both banks occupied), the sample is discarded. When a discarded sample has index all ones, pulse overflow for 1 cycle and increment drop_count, saturating at 255.
- Read FSM:
  - IDLE: if full[rd_bank], go to STREAM with rd_addr = 0.
  - STREAM: issue a RAM read at rd_addr every cycle and increment rd_addr. The output register follows 1 cycle later:
    - fft_read_valid = 1
    - fft_address = the address issued the previous cycle
    - data from the RAM
    - fft_done is set with the first valid cycle.
    - After issuing address all ones, go to DRAIN.
  - DRAIN: last valid cycle (address 511). Clear full[rd_bank], toggle rd_bank, go to WAIT_ACK.
  - WAIT_ACK: fft_read_valid = 0 and fft_done held at 1. On fsm_done = 1: fft_done goes to 0 next cycle, then IDLE.
- Stream timing: exactly 2**ADDR_W consecutive valid cycles with addresses 0..511 ascending, no gaps.
- Latency: with the read side in IDLE, the first valid cycle comes 3 clocks after the edge that samples the closing sample (edge 1: flag set; edge 2: IDLE to STREAM; edge 3: output register).
- fsm_done while in IDLE or STREAM is ignored.
- When fft_read_valid = 0, fft_address and the data outputs hold their last values.
- Same-cycle events:
  - A write closing one bank and a read clearing the other bank are independent; both take effect.
  - A closing write and a drop are mutually exclusive by construction.
  - If the closing write hits full[rd_bank] while the read FSM is in IDLE, STREAM starts the following cycle.

Test Plan:
- Single frame, natural order, re = index, im = -index -> 512 consecutive valid cycles; fft_address 0..511; data_in_real = k, data_in_imag = -k (18-bit). fft_done rises with the first valid cycle and falls 1 cycle after a fsm_done pulse. overflow never asserts.
- Frame delivered in bit-reversed index order with xk_dv low on every third cycle -> output in natural order with correct data; first valid 3 clocks after the index-511 sample.
- Second frame (re = 1000 + k) completes during the first stream -> after fsm_done, the second frame streams from address 0 with correct data, no overflow, and drop_count = 0.
- Third frame arrives while both banks are full -> overflow pulses once at its index-511 sample; drop_count = 1; none of its data ever appears on the outputs.
- Reset asserted while fft_address = 200 is being presented -> fft_read_valid, fft_done and fft_address are 0 immediately. A fresh frame after release streams from address 0 with correct data.
- fsm_done pulsed during STREAM -> ignored; all 512 valid cycles are still delivered; fft_done remains high until a later fsm_done pulse.

Source files
------------

// File: rtl/fft_result_streamer_if.sv
// Bus bundle between the FFT unload port, the result streamer and main_fsm.
// The streamer takes the slave view; the producer/consumer side takes master.
interface fft_result_streamer_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 18
);
    logic                     xk_dv;
    logic [ADDR_W-1:0]        xk_index;
    logic signed [DATA_W-1:0] xk_re;
    logic signed [DATA_W-1:0] xk_im;
    logic                     fsm_done;

    logic                     fft_done;
    logic [ADDR_W-1:0]        fft_address;
    logic                     fft_read_valid;
    logic signed [DATA_W-1:0] data_in_real;
    logic signed [DATA_W-1:0] data_in_imag;
    logic                     overflow;
    logic [7:0]               drop_count;
    logic                     busy;

    modport slave (
        input  xk_dv, xk_index, xk_re, xk_im, fsm_done,
        output fft_done, fft_address, fft_read_valid, data_in_real, data_in_imag,
               overflow, drop_count, busy
    );

    modport master (
        output xk_dv, xk_index, xk_re, xk_im, fsm_done,
        input  fft_done, fft_address, fft_read_valid, data_in_real, data_in_imag,
               overflow, drop_count, busy
    );
endinterface

// File: rtl/fft_result_streamer.sv
// Captures out-of-order FFT frames into a ping-pong buffer and replays each one
// in natural bin order to main_fsm, holding fft_done until the frame is acknowledged.
module fft_result_streamer #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 18
) (
    input  logic                  clk,
    input  logic                  reset,
    fft_result_streamer_if.slave  bus
);
    localparam int                DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        DRAIN    = 2'd2,
        WAIT_ACK = 2'd3
    } rd_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [2*DATA_W-1:0] bank0_mem [DEPTH];
    logic [2*DATA_W-1:0] bank1_mem [DEPTH];

    logic [1:0]               full_q, full_d;
    logic                     wr_bank_q;
    logic                     rd_bank_q;
    rd_state_e                state_q;
    logic [ADDR_W-1:0]        rd_addr_q;
    logic                     valid_q;
    logic                     done_q;
    logic [ADDR_W-1:0]        addr_out_q;
    logic signed [DATA_W-1:0] re_q, im_q;
    logic                     overflow_q;
    logic [7:0]               drop_count_q;

    logic                     wr_en, wr_close, drop_close, rd_issue;
    logic [2*DATA_W-1:0]      rd_word;

    // Capture side: a sample lands only if its target bank is still free.
    assign wr_en      = bus.xk_dv && !full_q[wr_bank_q];
    assign wr_close   = wr_en && (bus.xk_index == LAST);
    assign drop_close = bus.xk_dv && full_q[wr_bank_q] && (bus.xk_index == LAST);
    assign rd_issue   = (state_q == STREAM);
    assign rd_word    = rd_bank_q ? bank1_mem[rd_addr_q] : bank0_mem[rd_addr_q];

    always_ff @(posedge clk) begin
        if (wr_en && !wr_bank_q) bank0_mem[bus.xk_index] <= {bus.xk_re, bus.xk_im};
        if (wr_en &&  wr_bank_q) bank1_mem[bus.xk_index] <= {bus.xk_re, bus.xk_im};
    end

    // A closing write and a drain can never target the same bank: a closing
    // write needs its bank empty, a drain needs its bank full.
    always_comb begin
        full_d = full_q;
        if (wr_close)           full_d[wr_bank_q] = 1'b1;
        if (state_q == DRAIN)   full_d[rd_bank_q] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q       <= 2'b00;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            state_q      <= IDLE;
            rd_addr_q    <= '0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
            addr_out_q   <= '0;
            re_q         <= '0;
            im_q         <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            full_q     <= full_d;
            overflow_q <= drop_close;
            valid_q    <= rd_issue;
            if (wr_close)   wr_bank_q    <= ~wr_bank_q;
            if (drop_close) drop_count_q <= sat_inc8(drop_count_q);

            // Output register trails the RAM address by one cycle.
            if (rd_issue) begin
                addr_out_q <= rd_addr_q;
                re_q       <= rd_word[2*DATA_W-1:DATA_W];
                im_q       <= rd_word[DATA_W-1:0];
            end

            case (state_q)
                IDLE: begin
                    if (full_q[rd_bank_q]) begin
                        state_q   <= STREAM;
                        rd_addr_q <= '0;
                    end
                end
                STREAM: begin
                    rd_addr_q <= rd_addr_q + 1'b1;
                    done_q    <= 1'b1;
                    if (rd_addr_q == LAST) state_q <= DRAIN;
                end
                DRAIN: begin
                    rd_bank_q <= ~rd_bank_q;
                    state_q   <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (bus.fsm_done) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.fft_done       = done_q;
    assign bus.fft_address    = addr_out_q;
    assign bus.fft_read_valid = valid_q;
    assign bus.data_in_real   = re_q;
    assign bus.data_in_imag   = im_q;
    assign bus.overflow       = overflow_q;
    assign bus.drop_count     = drop_count_q;
    assign bus.busy           = (state_q != IDLE) || (|full_q);
endmodule

// File: tb/tb_fft_result_streamer.sv
// Bench for fft_result_streamer: frame scoreboard fed by the stimulus, checking
// every presented bin against the frames that were accepted, in acceptance order.
module tb_fft_result_streamer;
    localparam int AW = 9;
    localparam int DW = 18;
    localparam int N  = 1 << AW;

    typedef struct {
        int ord;      // 0 natural, 1 bit-reversed, 2 random permutation (511 last)
        int gap;      // >0: xk_dv low every gap-th cycle, <0: random gaps, 0: none
        int dmode;    // 0: re=k im=-k, 1: re=base+k im=k, 2: random, 3: full-scale extremes
        int base;
        int exp_lat;  // edges from the closing-sample edge (edge 1) to first valid
        int exp_ovf;  // overflow pulses expected for this frame
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_result_streamer_if #(.ADDR_W(AW), .DATA_W(DW)) ifc();
    fft_result_streamer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (ifc)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic signed [DW-1:0] exp_re [4][N];
    logic signed [DW-1:0] exp_im [4][N];
    logic signed [DW-1:0] cur_re [N];
    logic signed [DW-1:0] cur_im [N];
    int perm [N];
    int head = 0, tail = 0, n_acc = 0, n_drained = 0, idx = 0, n_ov = 0;
    int first_cyc = 0, close_cyc = 0, exp_drops = 0;
    logic [AW-1:0]        last_addr = '0;
    logic signed [DW-1:0] last_re = '0, last_im = '0;
    logic                 prev_done = 1'b0;

    vec_t vt [4];

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int bitrev(input int v);
        int r = 0;
        for (int b = 0; b < AW; b++) if (v[b]) r |= 1 << (AW - 1 - b);
        return r;
    endfunction

    task automatic send_frame(input int ord, input int gap, input int dmode, input int base);
        int acc, c, i, j, tmp;
        for (int k = 0; k < N; k++) begin
            case (dmode)
                0:       begin cur_re[k] = DW'(k);         cur_im[k] = DW'(-k); end
                1:       begin cur_re[k] = DW'(base + k);  cur_im[k] = DW'(k);  end
                2:       begin cur_re[k] = DW'($urandom);  cur_im[k] = DW'($urandom); end
                default: begin
                    cur_re[k] = k[0] ? DW'(131071)  : DW'(-131072);
                    cur_im[k] = k[0] ? DW'(-131072) : DW'(131071);
                end
            endcase
            perm[k] = (ord == 1) ? bitrev(k) : k;
        end
        if (ord == 2) begin
            for (int k = N - 2; k > 0; k--) begin
                j = $urandom_range(k, 0);
                tmp = perm[k]; perm[k] = perm[j]; perm[j] = tmp;
            end
        end
        acc = ((n_acc - n_drained) < 2) ? 1 : 0;
        if (acc == 1) begin
            for (int k = 0; k < N; k++) begin
                exp_re[tail][k] = cur_re[k];
                exp_im[tail][k] = cur_im[k];
            end
        end
        i = 0;
        c = 0;
        while (i < N) begin
            @(posedge clk); #1;
            if ((gap > 0 && (c % gap) == gap - 1) || (gap < 0 && $urandom_range(3, 0) == 0)) begin
                ifc.xk_dv    = 1'b0;
                ifc.xk_index = AW'($urandom);
                ifc.xk_re    = DW'($urandom);
                ifc.xk_im    = DW'($urandom);
            end else begin
                ifc.xk_dv    = 1'b1;
                ifc.xk_index = AW'(perm[i]);
                ifc.xk_re    = cur_re[perm[i]];
                ifc.xk_im    = cur_im[perm[i]];
                if (perm[i] == N - 1) begin
                    close_cyc = cyc;
                    if (acc == 1) begin
                        tail = (tail + 1) % 4;
                        n_acc++;
                    end else begin
                        exp_drops++;
                    end
                end
                i++;
            end
            c++;
        end
        @(posedge clk); #1;
        ifc.xk_dv = 1'b0;
    endtask

    task automatic wait_drained(input int target, input string name);
        int t = 0;
        while (n_drained < target && t < 4000) begin
            @(negedge clk); #1;
            t++;
        end
        chk(name, (n_drained >= target), 1);
    endtask

    task automatic do_ack();
        chk("done_before_ack", ifc.fft_done, 1);
        @(posedge clk); #1;
        ifc.fsm_done = 1'b1;
        @(posedge clk); #1;
        ifc.fsm_done = 1'b0;
        chk("done_after_ack", ifc.fft_done, 0);
    endtask

    task automatic pulse_done();
        @(posedge clk); #1;
        ifc.fsm_done = 1'b1;
        @(posedge clk); #1;
        ifc.fsm_done = 1'b0;
    endtask

    initial begin
        int tgt, ov0, t, base_d;
        ifc.xk_dv = 1'b0; ifc.xk_index = '0; ifc.xk_re = '0; ifc.xk_im = '0; ifc.fsm_done = 1'b0;

        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            forever begin
                @(negedge clk);
                if (rst) begin
                    head = tail; n_drained = n_acc; idx = 0;
                    last_addr = '0; last_re = '0; last_im = '0; prev_done = 1'b0;
                end else begin
                    if (ifc.fft_read_valid) begin
                        chk("valid_has_pending_frame", ((n_acc - n_drained) > 0), 1);
                        if (n_acc - n_drained > 0) begin
                            if (idx == 0) begin
                                chk("done_low_before_frame", prev_done, 0);
                                first_cyc = cyc;
                            end
                            chk("stream_addr", ifc.fft_address, idx);
                            chk("stream_re", ifc.data_in_real, exp_re[head][idx]);
                            chk("stream_im", ifc.data_in_imag, exp_im[head][idx]);
                            chk("done_during_stream", ifc.fft_done, 1);
                            idx++;
                            if (idx == N) begin
                                idx = 0;
                                head = (head + 1) % 4;
                                n_drained++;
                            end
                        end
                        last_addr = ifc.fft_address;
                        last_re   = ifc.data_in_real;
                        last_im   = ifc.data_in_imag;
                    end else begin
                        chk("stream_gap_at_bin", idx, 0);
                        chk("hold_addr", ifc.fft_address, last_addr);
                        chk("hold_re", ifc.data_in_real, last_re);
                        chk("hold_im", ifc.data_in_imag, last_im);
                    end
                    if (ifc.overflow) n_ov++;
                    prev_done = ifc.fft_done;
                end
            end
            begin
                #900000;
                $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", ifc.fft_read_valid, 0);
        chk("rst_done", ifc.fft_done, 0);
        chk("rst_addr", ifc.fft_address, 0);
        chk("rst_re", ifc.data_in_real, 0);
        chk("rst_im", ifc.data_in_imag, 0);
        chk("rst_overflow", ifc.overflow, 0);
        chk("rst_drop_count", ifc.drop_count, 0);
        chk("rst_busy", ifc.busy, 0);
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Single-frame vectors, each from an idle read side
        vt[0] = '{ord: 0, gap: 0,  dmode: 0, base: 0, exp_lat: 3, exp_ovf: 0};
        vt[1] = '{ord: 1, gap: 3,  dmode: 2, base: 0, exp_lat: 3, exp_ovf: 0};
        vt[2] = '{ord: 2, gap: -1, dmode: 2, base: 0, exp_lat: 3, exp_ovf: 0};
        vt[3] = '{ord: 0, gap: 0,  dmode: 3, base: 0, exp_lat: 3, exp_ovf: 0};
        for (int v = 0; v < 4; v++) begin
            tgt = n_drained + 1;
            ov0 = n_ov;
            chk("idle_busy", ifc.busy, 0);
            send_frame(vt[v].ord, vt[v].gap, vt[v].dmode, vt[v].base);
            wait_drained(tgt, "vec_frame_drained");
            chk("vec_latency", first_cyc - close_cyc, vt[v].exp_lat);
            chk("vec_overflow", n_ov - ov0, vt[v].exp_ovf);
            do_ack();
            repeat (4) @(posedge clk);
        end

        // Second frame captured while the first streams
        tgt = n_drained;
        ov0 = n_ov;
        send_frame(0, 0, 0, 0);
        send_frame(0, 0, 1, 1000);
        wait_drained(tgt + 1, "pp_first_drained");
        repeat (20) @(posedge clk);
        #1;
        chk("pp_held_until_ack", ifc.fft_read_valid, 0);
        chk("pp_done_held", ifc.fft_done, 1);
        do_ack();
        wait_drained(tgt + 2, "pp_second_drained");
        chk("pp_no_overflow", n_ov, ov0);
        chk("pp_drop_count", ifc.drop_count, 0);
        do_ack();

        // fsm_done in IDLE and during STREAM is ignored
        pulse_done();
        chk("idle_ack_ignored_done", ifc.fft_done, 0);
        tgt = n_drained + 1;
        send_frame(1, 0, 2, 0);
        t = 0;
        while (idx < 100 && t < 2000) begin @(negedge clk); #1; t++; end
        chk("mid_stream_reached", (idx >= 100), 1);
        pulse_done();
        chk("stream_ack_ignored", ifc.fft_done, 1);
        wait_drained(tgt, "mid_ack_frame_drained");
        chk("mid_ack_done_still_high", ifc.fft_done, 1);
        do_ack();

        // Fourth frame while both banks are held: dropped
        tgt = n_drained;
        ov0 = n_ov;
        send_frame(0, 0, 2, 0);
        wait_drained(tgt + 1, "drop_f1_drained");
        send_frame(2, 0, 1, 5000);
        send_frame(1, 0, 2, 0);
        send_frame(0, 0, 1, 20000);
        repeat (3) @(posedge clk);
        #1;
        chk("drop_overflow_pulses", n_ov - ov0, 1);
        chk("drop_count_one", ifc.drop_count, exp_drops);
        chk("drop_busy", ifc.busy, 1);
        chk("drop_no_stream", ifc.fft_read_valid, 0);
        do_ack();
        wait_drained(tgt + 2, "drop_f2_drained");
        do_ack();
        wait_drained(tgt + 3, "drop_f3_drained");
        do_ack();
        repeat (600) @(posedge clk);
        #1;
        chk("drop_nothing_pending", n_acc - n_drained, 0);
        chk("drop_total_overflow", n_ov - ov0, 1);

        // Randomized frames with random acknowledge delay
        base_d = n_drained;
        fork
            begin
                for (int f = 0; f < 6; f++) begin
                    int tt = 0;
                    while ((n_acc - n_drained) >= 2 && tt < 5000) begin @(negedge clk); #1; tt++; end
                    chk("rand_slot_free", ((n_acc - n_drained) < 2), 1);
                    send_frame($urandom_range(2, 0), ($urandom_range(1, 0) == 1) ? -1 : 0,
                               $urandom_range(3, 0), $urandom_range(9999, 0));
                    repeat ($urandom_range(30, 0)) @(posedge clk);
                end
            end
            begin
                for (int f = 0; f < 6; f++) begin
                    wait_drained(base_d + f + 1, "rand_frame_drained");
                    repeat ($urandom_range(20, 0)) @(posedge clk);
                    do_ack();
                end
            end
        join
        chk("rand_drop_count", ifc.drop_count, exp_drops);

        // Reset while bin 200 is on the outputs
        send_frame(0, 0, 0, 0);
        t = 0;
        while (!(ifc.fft_read_valid && ifc.fft_address == AW'(200)) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("reset_point_reached", ifc.fft_address, 200);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", ifc.fft_read_valid, 0);
        chk("mid_rst_done", ifc.fft_done, 0);
        chk("mid_rst_addr", ifc.fft_address, 0);
        chk("mid_rst_drop_count", ifc.drop_count, 0);
        chk("mid_rst_busy", ifc.busy, 0);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        tgt = n_drained + 1;
        send_frame(2, 3, 2, 0);
        wait_drained(tgt, "post_rst_drained");
        chk("post_rst_latency", first_cyc - close_cyc, 3);
        do_ack();
        repeat (20) @(posedge clk);
        #1;
        chk("end_nothing_pending", n_acc - n_drained, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
